// File: rtl/cpu_clk_pkg.sv
// Shared types and helpers for the CPU clock-enable / contention generator.
package cpu_clk_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } wait_state_t;

    localparam int unsigned SRC_RAM = 0;
    localparam int unsigned SRC_IO  = 1;

    // Bit width able to hold 0..n-1, never narrower than one bit
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned DEF_DIV        = 16;
    localparam int unsigned DEF_NUM_SPEEDS = 4;
    localparam int unsigned SPEED_W_DEF    = clog2_min1(DEF_NUM_SPEEDS);
    localparam int unsigned CNT_W_DEF      = clog2_min1(DEF_DIV);

endpackage

// File: rtl/contention_wait.sv
// One contention source: IDLE/WAIT state machine with a saturating timeout timer.
module contention_wait
    import cpu_clk_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4096
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic acc,
    input  logic cont,
    input  logic enable,
    input  logic flush,
    output logic wait_active,
    output logic timeout_err
);

    localparam int unsigned     TW     = clog2_min1(MAX_WAIT);
    localparam logic [TW-1:0]   T_LAST = TW'(MAX_WAIT - 1);

    wait_state_t   state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic          err_nxt;
    logic          acc_d, cont_d;
    logic          acc_rise_c, cont_fall_c;

    assign acc_rise_c  = acc & ~acc_d;
    assign cont_fall_c = cont_d & ~cont;
    assign wait_active = (state == WAIT);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state       <= IDLE;
            timer       <= '0;
            timeout_err <= 1'b0;
            acc_d       <= 1'b0;
            cont_d      <= 1'b0;
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            timeout_err <= err_nxt;
            acc_d       <= acc;
            cont_d      <= cont;
        end
    end

    // A clear condition in the same cycle as a set keeps the source idle
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        err_nxt   = timeout_err;
        case (state)
            IDLE: begin
                if (acc_rise_c && cont && enable && !cont_fall_c && !flush) begin
                    state_nxt = WAIT;
                    timer_nxt = '0;
                end
            end
            WAIT: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (timer == T_LAST) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                end else if (cont_fall_c) begin
                    state_nxt = IDLE;
                end else if (timer != '1) begin
                    timer_nxt = timer + TW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: rtl/cpu_clkgen.sv
// CPU phase enables, fixed fast/PSG enables, turbo speed select and
// per-source contention wait generation, all derived from clk_sys.
module cpu_clkgen
    import cpu_clk_pkg::*;
#(
    parameter int unsigned DIV        = 16,
    parameter int unsigned NUM_SPEEDS = 4,
    parameter int unsigned NSRC       = 2,
    parameter int unsigned PSG_DIV    = 12,
    parameter int unsigned MAX_WAIT   = 4096
) (
    input  logic                               clk_sys,
    input  logic                               reset,
    input  logic [clog2_min1(NUM_SPEEDS)-1:0]  speed,
    input  logic [NSRC-1:0]                    acc,
    input  logic [NSRC-1:0]                    cont,
    output logic                               ce_p,
    output logic                               ce_n,
    output logic                               ce_cpu_p,
    output logic                               ce_cpu_n,
    output logic                               ce_fast,
    output logic                               ce_psg,
    output logic                               cpu_en,
    output logic [NSRC-1:0]                    wait_active,
    output logic [NSRC-1:0]                    timeout_err,
    output logic [clog2_min1(NUM_SPEEDS)-1:0]  cur_speed
);

    localparam int unsigned SPEED_W = clog2_min1(NUM_SPEEDS);
    localparam int unsigned CNT_W   = clog2_min1(DIV);
    localparam int unsigned FAST_N  = DIV / 4;
    localparam int unsigned FAST_W  = clog2_min1(FAST_N);
    localparam int unsigned PSG_W   = clog2_min1(PSG_DIV);

    localparam logic [FAST_W-1:0] FAST_LAST = FAST_W'(FAST_N - 1);
    localparam logic [PSG_W-1:0]  PSG_LAST  = PSG_W'(PSG_DIV - 1);

    logic [CNT_W-1:0]   cnt;
    logic [FAST_W-1:0]  fast_cnt;
    logic [PSG_W-1:0]   psg_cnt;
    logic [31:0]        period_c;
    logic [CNT_W-1:0]   cnt_last_c, cnt_half_c;
    logic [SPEED_W-1:0] speed_clamped_c;
    logic               wrap_c, flush_c, enable_c;

    assign period_c   = DIV >> cur_speed;
    assign cnt_last_c = CNT_W'(period_c - 32'd1);
    assign cnt_half_c = CNT_W'(period_c >> 1);
    assign wrap_c     = (cnt == cnt_last_c);

    assign speed_clamped_c = (32'(speed) >= NUM_SPEEDS) ? SPEED_W'(NUM_SPEEDS - 1) : speed;

    // Waits are dropped on the wrap that enters a turbo speed
    assign flush_c  = wrap_c && (speed_clamped_c != '0);
    assign enable_c = (cur_speed == '0);

    assign ce_cpu_p = ce_p & cpu_en;
    assign ce_cpu_n = ce_n & cpu_en;

    // CPU phase counter; speed only changes on a cycle boundary
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cnt       <= '0;
            cur_speed <= '0;
            ce_p      <= 1'b0;
            ce_n      <= 1'b0;
            cpu_en    <= 1'b1;
        end else begin
            ce_p <= (cnt == '0);
            ce_n <= (cnt == cnt_half_c);
            if (cnt == '0) begin
                cpu_en <= ~|wait_active;
            end
            if (wrap_c) begin
                cnt       <= '0;
                cur_speed <= speed_clamped_c;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Speed-independent fast and PSG enables
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            fast_cnt <= '0;
            psg_cnt  <= '0;
            ce_fast  <= 1'b0;
            ce_psg   <= 1'b0;
        end else begin
            ce_fast  <= (fast_cnt == FAST_LAST);
            fast_cnt <= (fast_cnt == FAST_LAST) ? '0 : fast_cnt + FAST_W'(1);
            ce_psg   <= (psg_cnt == '0);
            psg_cnt  <= (psg_cnt == PSG_LAST) ? '0 : psg_cnt + PSG_W'(1);
        end
    end

    for (genvar i = 0; i < int'(NSRC); i++) begin : g_src
        contention_wait #(
            .MAX_WAIT (MAX_WAIT)
        ) u_wait (
            .clk_sys     (clk_sys),
            .reset       (reset),
            .acc         (acc[i]),
            .cont        (cont[i]),
            .enable      (enable_c),
            .flush       (flush_c),
            .wait_active (wait_active[i]),
            .timeout_err (timeout_err[i])
        );
    end

endmodule

// File: tb/tb_cpu_clkgen.sv
// Directed self-checking bench for cpu_clkgen (DIV=16, PSG_DIV=12, MAX_WAIT=64).
module tb_cpu_clkgen;
    import cpu_clk_pkg::*;

    logic                   clk_sys;
    logic                   reset;
    logic [SPEED_W_DEF-1:0] speed;
    logic [1:0]             acc, cont;
    logic                   ce_p, ce_n, ce_cpu_p, ce_cpu_n, ce_fast, ce_psg, cpu_en;
    logic [1:0]             wait_active, timeout_err;
    logic [SPEED_W_DEF-1:0] cur_speed;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int n;

    cpu_clkgen #(
        .DIV        (DEF_DIV),
        .NUM_SPEEDS (DEF_NUM_SPEEDS),
        .NSRC       (2),
        .PSG_DIV    (12),
        .MAX_WAIT   (64)
    ) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .speed       (speed),
        .acc         (acc),
        .cont        (cont),
        .ce_p        (ce_p),
        .ce_n        (ce_n),
        .ce_cpu_p    (ce_cpu_p),
        .ce_cpu_n    (ce_cpu_n),
        .ce_fast     (ce_fast),
        .ce_psg      (ce_psg),
        .cpu_en      (cpu_en),
        .wait_active (wait_active),
        .timeout_err (timeout_err),
        .cur_speed   (cur_speed)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic step(input int count = 1);
        repeat (count) begin
            @(posedge clk_sys);
            #1;
            cyc++;
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_v(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance until ce_p is seen, bounded
    task automatic sync_p(input int limit);
        int k = 0;
        step();
        while (!ce_p && k < limit) begin
            step();
            k++;
        end
        chk_b("sync_ce_p", ce_p, 1'b1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk_b({tag, "_ce_p"}, ce_p, 1'b0);
        chk_b({tag, "_ce_n"}, ce_n, 1'b0);
        chk_b({tag, "_ce_fast"}, ce_fast, 1'b0);
        chk_b({tag, "_ce_psg"}, ce_psg, 1'b0);
        chk_b({tag, "_cpu_en"}, cpu_en, 1'b1);
        chk_v({tag, "_wait"}, 32'(wait_active), 32'd0);
        chk_v({tag, "_terr"}, 32'(timeout_err), 32'd0);
        chk_v({tag, "_speed"}, 32'(cur_speed), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        speed = '0;
        acc   = '0;
        cont  = '0;
        step(3);
        chk_reset_state("reset");

        // Speed 0 periods: ce_p every 16, ce_n 8 later, fast 4, psg 12
        reset = 1'b0;
        cyc   = 0;
        step();
        chk_b("first_ce_p", ce_p, 1'b1);
        chk_b("first_ce_cpu_p", ce_cpu_p, 1'b1);
        chk_b("first_ce_psg", ce_psg, 1'b1);
        chk_b("first_ce_fast", ce_fast, 1'b0);
        while (cyc < 32) begin
            step();
            chk_b($sformatf("s0_ce_p@%0d", cyc), ce_p, (cyc % 16) == 1);
            chk_b($sformatf("s0_ce_cpu_p@%0d", cyc), ce_cpu_p, (cyc % 16) == 1);
            chk_b($sformatf("s0_ce_n@%0d", cyc), ce_n, (cyc % 16) == 9);
            chk_b($sformatf("s0_ce_fast@%0d", cyc), ce_fast, (cyc % 4) == 0);
            chk_b($sformatf("s0_ce_psg@%0d", cyc), ce_psg, (cyc % 12) == 1);
            chk_b($sformatf("s0_cpu_en@%0d", cyc), cpu_en, 1'b1);
        end

        // Speed 0->2 requested at cnt==5; current 16-cycle period completes
        step(5);
        speed = 2'd2;
        while (cyc < 64) begin
            step();
            chk_b($sformatf("sp_ce_p@%0d", cyc), ce_p, (cyc < 49) ? ((cyc % 16) == 1) : ((cyc % 4) == 1));
            chk_b($sformatf("sp_ce_n@%0d", cyc), ce_n, (cyc < 49) ? ((cyc % 16) == 9) : ((cyc % 4) == 3));
            chk_b($sformatf("sp_ce_fast@%0d", cyc), ce_fast, (cyc % 4) == 0);
            chk_v($sformatf("sp_speed@%0d", cyc), 32'(cur_speed), (cyc >= 48) ? 32'd2 : 32'd0);
        end

        // Back to speed 0 at the wrap on cycle 68
        speed = 2'd0;
        step(3);
        chk_v("back_speed_before", 32'(cur_speed), 32'd2);
        step();
        chk_v("back_speed_after", 32'(cur_speed), 32'd0);
        step();
        chk_b("back_ce_p", ce_p, 1'b1);

        // Contention on RAM: acc rises at cnt==3 with cont high
        cont[SRC_RAM] = 1'b1;
        step(2);
        acc[SRC_RAM] = 1'b1;
        step();
        chk_b("ram_wait_set", wait_active[SRC_RAM], 1'b1);
        chk_b("ram_cpu_en_still", cpu_en, 1'b1);
        step(13);
        chk_b("ram_blk_ce_p", ce_p, 1'b1);
        chk_b("ram_blk_cpu_en", cpu_en, 1'b0);
        chk_b("ram_blk_ce_cpu_p", ce_cpu_p, 1'b0);
        step(8);
        chk_b("ram_blk_ce_n", ce_n, 1'b1);
        chk_b("ram_blk_ce_cpu_n", ce_cpu_n, 1'b0);
        cont[SRC_RAM] = 1'b0;
        step();
        chk_b("ram_wait_clr", wait_active[SRC_RAM], 1'b0);
        chk_b("ram_cpu_en_held", cpu_en, 1'b0);
        step(7);
        chk_b("ram_run_ce_p", ce_p, 1'b1);
        chk_b("ram_run_cpu_en", cpu_en, 1'b1);
        chk_b("ram_run_ce_cpu_p", ce_cpu_p, 1'b1);
        step(8);
        chk_b("ram_run_ce_cpu_n", ce_cpu_n, 1'b1);

        // I/O source sets normally, then acc rise with cont fall stays idle
        cont[SRC_IO] = 1'b1;
        step();
        acc[SRC_IO] = 1'b1;
        step();
        chk_v("io_wait_set", 32'(wait_active), 32'b10);
        cont[SRC_IO] = 1'b0;
        step();
        chk_b("io_wait_clr", wait_active[SRC_IO], 1'b0);
        acc[SRC_IO]  = 1'b0;
        cont[SRC_IO] = 1'b1;
        step();
        acc[SRC_IO]  = 1'b1;
        cont[SRC_IO] = 1'b0;
        step();
        chk_b("io_same_cycle", wait_active[SRC_IO], 1'b0);
        step();
        chk_b("io_same_cycle_hold", wait_active[SRC_IO], 1'b0);

        // Timeout: cont held high, wait lasts MAX_WAIT cycles then flags error
        acc[SRC_RAM]  = 1'b0;
        cont[SRC_RAM] = 1'b1;
        step();
        acc[SRC_RAM] = 1'b1;
        step();
        chk_b("to_wait_set", wait_active[SRC_RAM], 1'b1);
        chk_v("to_no_err_yet", 32'(timeout_err), 32'd0);
        n = 1;
        while (wait_active[SRC_RAM] && n < 200) begin
            step();
            if (wait_active[SRC_RAM]) n++;
        end
        chk_v("to_wait_len", 32'(n), 32'd64);
        chk_v("to_err_set", 32'(timeout_err), 32'b01);
        step(3);
        chk_v("to_err_sticky", 32'(timeout_err), 32'b01);
        chk_b("to_no_reentry", wait_active[SRC_RAM], 1'b0);

        // Turbo request while waiting: wait flushed on the wrap
        acc[SRC_RAM] = 1'b0;
        sync_p(40);
        acc[SRC_RAM] = 1'b1;
        step();
        chk_b("tb_wait_set", wait_active[SRC_RAM], 1'b1);
        speed = 2'd1;
        step(13);
        chk_v("tb_speed_pre", 32'(cur_speed), 32'd0);
        chk_b("tb_wait_pre", wait_active[SRC_RAM], 1'b1);
        step();
        chk_v("tb_speed_post", 32'(cur_speed), 32'd1);
        chk_v("tb_wait_flushed", 32'(wait_active), 32'd0);
        step();
        chk_b("tb_ce_p", ce_p, 1'b1);
        step(3);
        chk_b("tb_ce_n_early", ce_n, 1'b0);
        step();
        chk_b("tb_ce_n", ce_n, 1'b1);
        step(4);
        chk_b("tb_ce_p_period8", ce_p, 1'b1);
        acc[SRC_RAM]  = 1'b0;
        cont[SRC_RAM] = 1'b0;
        step();
        cont[SRC_RAM] = 1'b1;
        step();
        acc[SRC_RAM] = 1'b1;
        step();
        chk_v("tb_no_wait", 32'(wait_active), 32'd0);
        step();
        chk_v("tb_no_wait_hold", 32'(wait_active), 32'd0);
        chk_v("tb_err_still", 32'(timeout_err), 32'b01);

        // Mid-operation reset
        reset = 1'b1;
        step();
        chk_reset_state("mid_reset");
        reset = 1'b0;
        speed = 2'd0;
        step();
        chk_b("post_reset_ce_p", ce_p, 1'b1);
        chk_v("post_reset_speed", 32'(cur_speed), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
